memory_arbiter: RTL and testbench

Single-port RAM arbiter between the instruction-fetch and data-access request paths. It takes the iREN, dREN and dWEN strobes produced by the request unit, grants the one shared RAM port to one requester at a time, and holds the grant until RAM reports ACCESS. It returns per-side wait/load signals that the caches and request unit treat as ihit/dhit. Data has priority, and a bounded-streak rule prevents instruction-fetch starvation.

---
 rtl/cpu_types_pkg.sv | 19 +
 rtl/memory_arbiter.sv | 116 +++++++++++
 tb/tb_memory_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM handshake state, machine word and arbiter state.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISERV = 2'd1,
        DSERV = 2'd2
    } arb_state_t;

endpackage

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter: data has priority over instruction fetch, and a bounded
// streak of data grants forces an instruction grant so fetch cannot starve.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned DSTREAK_MAX = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);

    localparam int unsigned StreakW = $clog2(DSTREAK_MAX + 1);
    localparam logic [StreakW-1:0] StreakMax = StreakW'(DSTREAK_MAX);

    arb_state_t         state_q, state_d;
    logic [StreakW-1:0] streak_q, streak_d;
    ramstate_t          rs;
    logic               d_req;
    logic               force_i;
    logic               xfer_end;

    assign rs       = ramstate_t'(ramstate);
    assign d_req    = dREN | dWEN;
    assign force_i  = iREN && (streak_q == StreakMax);
    // ERROR ends the attempt like ACCESS does; the held request is simply re-arbitrated.
    assign xfer_end = (rs == ACCESS) || (rs == ERROR);

    // Next-state and streak update: arbitrate in IDLE, leave a serving state on end or withdrawal.
    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        unique case (state_q)
            IDLE: begin
                if (d_req && !force_i) begin
                    state_d = DSERV;
                    if (iREN) begin
                        if (streak_q != StreakMax) streak_d = streak_q + 1'b1;
                    end else begin
                        streak_d = '0;
                    end
                end else if (iREN) begin
                    state_d  = ISERV;
                    streak_d = '0;
                end
            end
            ISERV: if (!iREN || xfer_end) state_d = IDLE;
            DSERV: if (!d_req || xfer_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and streak registers; reset drops any pending access immediately.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end

    // RAM strobes and per-side wait/load, combinational from state and live inputs.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        iload    = '0;
        dwait    = 1'b1;
        dload    = '0;
        unique case (state_q)
            ISERV: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                // A withdrawn request never completes, even if RAM says ACCESS.
                if (iREN && rs == ACCESS) begin
                    iwait = 1'b0;
                    iload = ramload;
                end
            end
            DSERV: begin
                ramaddr = daddr;
                if (dWEN) begin
                    ramWEN   = 1'b1;
                    ramstore = dstore;
                end else begin
                    ramREN = 1'b1;
                end
                if (d_req && rs == ACCESS) begin
                    dwait = 1'b0;
                    dload = ramload;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios plus random traffic,
// all compared against a grant-owner reference model.
module tb_memory_arbiter;

    localparam int DMAX = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        iREN = 1'b0;
    logic [31:0] iaddr = '0;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN = 1'b0;
    logic        dWEN = 1'b0;
    logic [31:0] daddr = '0;
    logic [31:0] dstore = '0;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload = '0;
    logic [1:0]  ramstate = 2'd0;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: who currently owns the RAM (0 none, 1 fetch, 2 data) and how many
    // data grants in a row have been made while fetch was waiting.
    int owner = 0;
    int dstreak = 0;

    memory_arbiter #(.DSTREAK_MAX(DMAX)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare every output to the model, advance the model, move to the next negedge.
    task automatic step();
        bit          dreq;
        bit          done;
        logic        e_rren, e_rwen, e_iwait, e_dwait;
        logic [31:0] e_addr, e_store, e_iload, e_dload;
        dreq    = dREN | dWEN;
        done    = 1'b0;
        e_rren  = 0; e_rwen = 0; e_addr = 0; e_store = 0;
        e_iwait = 1; e_dwait = 1; e_iload = 0; e_dload = 0;
        if (owner == 1) begin
            e_rren = 1;
            e_addr = iaddr;
            if (iREN && ramstate == 2'd2) begin
                e_iwait = 0;
                e_iload = ramload;
            end
        end else if (owner == 2) begin
            e_addr = daddr;
            if (dWEN) begin
                e_rwen  = 1;
                e_store = dstore;
            end else begin
                e_rren = 1;
            end
            if (dreq && ramstate == 2'd2) begin
                e_dwait = 0;
                e_dload = ramload;
            end
        end
        check_eq("ramREN", 32'(ramREN), 32'(e_rren));
        check_eq("ramWEN", 32'(ramWEN), 32'(e_rwen));
        check_eq("ramaddr", ramaddr, e_addr);
        check_eq("ramstore", ramstore, e_store);
        check_eq("iwait", 32'(iwait), 32'(e_iwait));
        check_eq("iload", iload, e_iload);
        check_eq("dwait", 32'(dwait), 32'(e_dwait));
        check_eq("dload", dload, e_dload);

        // Ownership after this edge.
        if (owner == 0) begin
            if (dreq && !(iREN && dstreak == DMAX)) begin
                owner   = 2;
                dstreak = iREN ? ((dstreak + 1 > DMAX) ? DMAX : dstreak + 1) : 0;
            end else if (iREN) begin
                owner   = 1;
                dstreak = 0;
            end
        end else if (owner == 1) begin
            if (!iREN || ramstate >= 2'd2) owner = 0;
        end else begin
            if (!dreq || ramstate >= 2'd2) owner = 0;
        end
        done = 1'b1;
        if (done) @(negedge CLK);
    endtask

    // Assert reset for one edge, checking reset outputs while it is held.
    task automatic do_reset(input string tag);
        RST = 1'b1;
        #1;
        check_eq({tag, "_ramREN"}, 32'(ramREN), 32'd0);
        check_eq({tag, "_ramWEN"}, 32'(ramWEN), 32'd0);
        check_eq({tag, "_ramaddr"}, ramaddr, 32'd0);
        check_eq({tag, "_ramstore"}, ramstore, 32'd0);
        check_eq({tag, "_iwait"}, 32'(iwait), 32'd1);
        check_eq({tag, "_dwait"}, 32'(dwait), 32'd1);
        check_eq({tag, "_iload"}, iload, 32'd0);
        check_eq({tag, "_dload"}, dload, 32'd0);
        owner   = 0;
        dstreak = 0;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic clear_inputs();
        iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0;
        ramload = 0; ramstate = 2'd0;
    endtask

    initial begin
        int grants[$];
        int exp_order[6];

        clear_inputs();
        do_reset("por");

        // Reset mid-transaction drops the access in the same cycle.
        dREN = 1; daddr = 32'h40; ramstate = 2'd1;
        #1; step();
        #1; check_eq("mid_ramREN_before", 32'(ramREN), 32'd1);
        step();
        do_reset("midrst");
        clear_inputs();

        // Single read with two BUSY cycles.
        dREN = 1; daddr = 32'h100; ramstate = 2'd1; ramload = 32'hDEADBEEF;
        #1; check_eq("rd_c0_dwait", 32'(dwait), 32'd1); step();
        #1; check_eq("rd_c1_ramaddr", ramaddr, 32'h100); check_eq("rd_c1_dwait", 32'(dwait), 32'd1);
        step();
        #1; check_eq("rd_c2_dwait", 32'(dwait), 32'd1); step();
        ramstate = 2'd2;
        #1; check_eq("rd_c3_dwait", 32'(dwait), 32'd0); check_eq("rd_c3_dload", dload, 32'hDEADBEEF);
        step();
        dREN = 0; ramstate = 2'd0;
        #1; check_eq("rd_c4_dwait", 32'(dwait), 32'd1); step();

        // Write wins over read when both are asserted.
        do_reset("wr");
        dREN = 1; dWEN = 1; daddr = 32'h200; dstore = 32'h12345678; ramstate = 2'd1;
        #1; step();
        #1;
        check_eq("wr_ramWEN", 32'(ramWEN), 32'd1);
        check_eq("wr_ramREN", 32'(ramREN), 32'd0);
        check_eq("wr_ramstore", ramstore, 32'h12345678);
        step();
        clear_inputs();
        #1; step();

        // Anti-starvation: both sides hold requests, RAM always answers ACCESS.
        do_reset("starve");
        iREN = 1; dREN = 1; iaddr = 32'h1000; daddr = 32'h2000; ramstate = 2'd2;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (ramREN || ramWEN) grants.push_back((ramaddr == 32'h1000) ? 1 : 2);
            step();
        end
        exp_order = '{2, 2, 2, 2, 1, 2};
        check_eq("starve_count", 32'(grants.size()), 32'd6);
        for (int g = 0; g < 6 && g < grants.size(); g++)
            check_eq($sformatf("starve_grant%0d", g), 32'(grants[g]), 32'(exp_order[g]));
        clear_inputs();

        // ERROR then ACCESS on retry.
        do_reset("err");
        iREN = 1; iaddr = 32'h300; ramload = 32'hCAFE0001;
        #1; step();
        ramstate = 2'd3;
        #1; check_eq("err_iwait_err", 32'(iwait), 32'd1); step();
        ramstate = 2'd1;
        #1; check_eq("err_iwait_bubble", 32'(iwait), 32'd1); step();
        ramstate = 2'd2;
        #1; check_eq("err_iwait_done", 32'(iwait), 32'd0); check_eq("err_iload", iload, 32'hCAFE0001);
        step();
        clear_inputs();

        // Withdrawal during BUSY.
        do_reset("wd");
        iREN = 1; iaddr = 32'h400; ramstate = 2'd1;
        #1; step();
        #1; check_eq("wd_busy_iwait", 32'(iwait), 32'd1); step();
        iREN = 0;
        #1; check_eq("wd_drop_iwait", 32'(iwait), 32'd1); step();
        #1; check_eq("wd_idle_ramREN", 32'(ramREN), 32'd0); check_eq("wd_idle_iwait", 32'(iwait), 32'd1);
        step();

        // Random traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 199) == 0) do_reset("rand_rst");
            iREN     = ($urandom_range(0, 99) < 60);
            dREN     = ($urandom_range(0, 99) < 50);
            dWEN     = ($urandom_range(0, 99) < 30);
            iaddr    = $urandom;
            daddr    = $urandom;
            dstore   = $urandom;
            ramload  = $urandom;
            ramstate = 2'($urandom_range(0, 3));
            #1; step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
